// File: rtl/seq_mult_ctrl.sv
// Shift-add multiplier sequencer driving a shared N-bit ALU.
// One partial product per cycle; product registered on completion.
module seq_mult_ctrl #(
    parameter int N  = 8,
    parameter int CW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   multiplicand,
    input  logic [N-1:0]   multiplier,
    output logic [N-1:0]   alu_a,
    output logic [N-1:0]   alu_b,
    output logic [2:0]     alu_i,
    input  logic [N-1:0]   alu_f,
    input  logic           alu_cout,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_acc;
    logic [N-1:0]     r_q;
    logic [N-1:0]     r_m;
    logic [CW-1:0]    r_cnt;
    logic [2*N-1:0]   r_prod;
    logic [2*N-1:0]   w_step;
    logic             w_last;

    // N+1-bit sum shifted right one place; carry lands in acc MSB
    assign w_step = {alu_cout, alu_f, r_q[N-1:1]};
    assign w_last = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_q     <= multiplier;
                        r_m     <= multiplicand;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    {r_acc, r_q} <= w_step;
                    r_cnt        <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_prod  <= w_step;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_a   = r_acc;
    assign alu_b   = r_q[0] ? r_m : '0;
    assign alu_i   = 3'b000;
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_prod;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl paired with a behavioural ADD-only ALU.
// Table of operand/product vectors plus hand-written abort and back-to-back cases.
module tb_seq_mult_ctrl;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [N-1:0]   m_in;
    logic [N-1:0]   q_in;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [2:0]     alu_i;
    logic [N-1:0]   alu_f;
    logic           alu_cout;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared ALU: only opcode 000 (ADD) is modelled
    assign {alu_cout, alu_f} = (alu_i == 3'b000)
                             ? ({1'b0, alu_a} + {1'b0, alu_b})
                             : '0;

    seq_mult_ctrl #(.N(N), .CW(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (m_in),
        .multiplier   (q_in),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_i        (alu_i),
        .alu_f        (alu_f),
        .alu_cout     (alu_cout),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  q;
        logic [15:0] exp;
        logic        inject;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One op: pulse start, observe 14 cycles, optionally try a mid-RUN start
    task automatic run_op(input logic [7:0] m, input logic [7:0] q,
                          input logic inject, input logic [15:0] exp,
                          input string tag);
        int nbusy;
        int ndone;
        logic [15:0] prev;
        logic [15:0] got;
        logic held;
        nbusy = 0;
        ndone = 0;
        held  = 1'b1;
        got   = '0;
        @(negedge clk);
        prev  = product;
        m_in  = m;
        q_in  = q;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (busy) begin
                nbusy++;
                if (product !== prev) held = 1'b0;
            end
            if (done) begin
                ndone++;
                got = product;
            end
            if (inject && i == 3) begin
                m_in  = 8'd77;
                q_in  = 8'd99;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, " product"}, 32'(got), 32'(exp));
        chk({tag, " busy_cycles"}, nbusy, 8);
        chk({tag, " done_pulses"}, ndone, 1);
        chk({tag, " product_held"}, 32'(held), 1);
    endtask

    vec_t vecs[6];

    initial begin
        int gap;
        int ndone;
        int waitc;
        logic [15:0] p1;
        logic [15:0] p2;
        logic seen_busy2;

        vecs[0] = '{8'd13,  8'd11,  16'h008F, 1'b0};
        vecs[1] = '{8'd255, 8'd255, 16'hFE01, 1'b0};
        vecs[2] = '{8'd0,   8'd200, 16'h0000, 1'b0};
        vecs[3] = '{8'd1,   8'd7,   16'h0007, 1'b1};
        vecs[4] = '{8'd128, 8'd2,   16'h0100, 1'b0};
        vecs[5] = '{8'd170, 8'd85,  16'h3872, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        m_in  = '0;
        q_in  = '0;
        repeat (2) @(negedge clk);
        chk("rst product", 32'(product), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst alu_a", 32'(alu_a), 0);
        chk("rst alu_b", 32'(alu_b), 0);
        chk("rst alu_i", 32'(alu_i), 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++)
            run_op(vecs[v].m, vecs[v].q, vecs[v].inject, vecs[v].exp,
                   $sformatf("vec%0d", v));

        // Start held high across two back-to-back ops
        @(negedge clk);
        m_in  = 8'd3;
        q_in  = 8'd5;
        start = 1'b1;
        ndone = 0;
        gap = 0;
        p1 = '0;
        p2 = '0;
        seen_busy2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    p1   = product;
                    m_in = 8'd200;
                    q_in = 8'd2;
                end else if (ndone == 2) begin
                    p2    = product;
                    start = 1'b0;
                    break;
                end
            end else if (ndone == 1 && !busy && !seen_busy2) begin
                gap++;
            end else if (ndone == 1 && busy) begin
                seen_busy2 = 1'b1;
            end
        end
        start = 1'b0;
        chk("held op1 product", 32'(p1), 32'h000F);
        chk("held op2 product", 32'(p2), 32'h0190);
        chk("held done count", ndone, 2);
        chk("held idle gap", gap, 1);

        // Reset in the middle of RUN aborts with no done
        @(negedge clk);
        m_in  = 8'd9;
        q_in  = 8'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy before rst", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 32'(busy), 0);
        chk("abort done", 32'(done), 0);
        chk("abort product", 32'(product), 0);
        ndone = 0;
        waitc = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
            waitc++;
        end
        chk("abort no activity", ndone, 0);

        run_op(8'd6, 8'd7, 1'b0, 16'h002A, "post_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
